// File: rtl/vec_lane_sel.sv
// Two-stage vector lane permutation pipeline: S1 captures the operation, S2 applies
// SELECT / BCAST / ROTATE / REVERSE and holds the result under valid/ready backpressure.
module vec_lane_sel #(
   parameter int W     = 8,
   parameter int LANES = 16,
   parameter int SW    = $clog2(LANES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [W*LANES-1:0]   in_data,
   input  logic [SW-1:0]        in_sel,
   input  logic [1:0]           in_mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   output logic [W*LANES-1:0]   out_data,
   output logic                 out_valid,
   input  logic                 out_ready
);

   typedef enum logic [1:0] {
      MODE_SELECT  = 2'b00,
      MODE_BCAST   = 2'b01,
      MODE_ROTATE  = 2'b10,
      MODE_REVERSE = 2'b11
   } mode_e;

   logic               s1_valid_q, s1_valid_d;
   logic [W*LANES-1:0] s1_data_q,  s1_data_d;
   logic [SW-1:0]      s1_sel_q,   s1_sel_d;
   mode_e              s1_mode_q,  s1_mode_d;
   logic               out_valid_q, out_valid_d;
   logic [W*LANES-1:0] out_data_q,  out_data_d;

   logic               s1_load;
   logic               s2_load;
   logic               in_fire;
   logic [W*LANES-1:0] perm;
   logic [W-1:0]       lane_in  [LANES];
   logic [W-1:0]       lane_out [LANES];
   logic [W-1:0]       picked;

   // S1 may refill in the same cycle S2 drains, so in_ready depends combinationally on out_ready.
   always_comb begin
      s2_load  = !out_valid_q || out_ready;
      s1_load  = !s1_valid_q || s2_load;
      in_ready = s1_load && !flush;
      in_fire  = in_valid && in_ready;
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         lane_in[i] = s1_data_q[i*W +: W];
      end
      picked = lane_in[s1_sel_q];
      for (int i = 0; i < LANES; i++) begin
         lane_out[i] = '0;
         unique case (s1_mode_q)
            MODE_SELECT:  lane_out[i] = (i == 0) ? picked : '0;
            MODE_BCAST:   lane_out[i] = picked;
            // SW-bit add wraps modulo LANES because LANES is a power of two.
            MODE_ROTATE:  lane_out[i] = lane_in[SW'(i) + s1_sel_q];
            MODE_REVERSE: lane_out[i] = lane_in[LANES-1-i];
            default:      lane_out[i] = '0;
         endcase
      end
      perm = '0;
      for (int i = 0; i < LANES; i++) begin
         perm[i*W +: W] = lane_out[i];
      end
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_data_d   = s1_data_q;
      s1_sel_d    = s1_sel_q;
      s1_mode_d   = s1_mode_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (flush) begin
         s1_valid_d = 1'b0;
      end else if (s1_load) begin
         s1_valid_d = in_fire;
      end

      if (in_fire) begin
         s1_data_d = in_data;
         s1_sel_d  = in_sel;
         s1_mode_d = mode_e'(in_mode);
      end

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (s2_load) begin
         out_valid_d = s1_valid_q;
      end

      if (!flush && s2_load && s1_valid_q) begin
         out_data_d = perm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_sel_q    <= '0;
         s1_mode_q   <= MODE_SELECT;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_sel_q    <= s1_sel_d;
         s1_mode_q   <= s1_mode_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_vec_lane_sel.sv
// Scoreboard bench for vec_lane_sel: stimulus pushes expected vectors on acceptance,
// an output monitor pops and compares on every output transfer.
module tb_vec_lane_sel;
   localparam int W     = 8;
   localparam int LANES = 16;
   localparam int SW    = 4;
   localparam int N     = W*LANES;

   localparam logic [N-1:0] BASE     = 128'h1F1E1D1C1B1A19181716151413121110;
   localparam logic [N-1:0] EXP_SEL5 = 128'h00000000000000000000000000000015;
   localparam logic [N-1:0] EXP_SEL0 = 128'h00000000000000000000000000000010;
   localparam logic [N-1:0] EXP_SELF = 128'h0000000000000000000000000000001F;
   localparam logic [N-1:0] EXP_BC15 = 128'h1F1F1F1F1F1F1F1F1F1F1F1F1F1F1F1F;
   localparam logic [N-1:0] EXP_BC0  = 128'h10101010101010101010101010101010;
   localparam logic [N-1:0] EXP_ROT3 = 128'h1211101F1E1D1C1B1A19181716151413;
   localparam logic [N-1:0] EXP_REV  = 128'h101112131415161718191A1B1C1D1E1F;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [N-1:0]  in_data = '0;
   logic [SW-1:0] in_sel = '0;
   logic [1:0]    in_mode = 2'b00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          flush = 1'b0;
   logic [N-1:0]  out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [N-1:0]  sb [$];
   logic [N-1:0]  mon_exp;
   bit            rand_ready = 1'b0;

   always #5 clk = ~clk;

   vec_lane_sel #(.W(W), .LANES(LANES), .SW(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_mode   (in_mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic logic [N-1:0] model(input logic [1:0] m, input int sel, input logic [N-1:0] d);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         case (m)
            2'b00:   r[i*W +: W] = (i == 0) ? d[sel*W +: W] : '0;
            2'b01:   r[i*W +: W] = d[sel*W +: W];
            2'b10:   r[i*W +: W] = d[((i + sel) % LANES)*W +: W];
            default: r[i*W +: W] = d[(LANES-1-i)*W +: W];
         endcase
      end
      return r;
   endfunction

   // Output monitor: a transfer counts only if neither reset nor flush overrides it.
   always @(negedge clk) begin
      if (rst_n && !flush && out_valid === 1'b1 && out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %h expected none", out_data);
         end else begin
            mon_exp = sb.pop_front();
            check("out_data", out_data, mon_exp);
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Called and returns at posedge+1; leaves in_valid asserted.
   task automatic issue(input logic [1:0] m, input logic [SW-1:0] s, input logic [N-1:0] d,
                        input logic [N-1:0] e, output int waits);
      in_mode  = m;
      in_sel   = s;
      in_data  = d;
      in_valid = 1'b1;
      waits    = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (in_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=%b expected 1 within 200 cycles", in_ready);
      end else begin
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, w1, w2, t;
      logic [1:0]   rm;
      logic [SW-1:0] rs;
      logic [N-1:0] rd;

      // asynchronous reset, no clock edge yet
      #1 rst_n = 1'b0;
      #1;
      check1("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check1("rst_in_ready", in_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1 check1("rst_in_ready_hold", in_ready, 1'b1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 check1("post_rst_in_ready", in_ready, 1'b1);

      // SELECT sel=5: latency 2, valid for exactly one cycle
      issue(2'b00, 4'd5, BASE, EXP_SEL5, w0);
      in_valid = 1'b0;
      @(negedge clk) check1("sel_lat_t0", out_valid, 1'b0);
      @(negedge clk) check1("sel_lat_t1", out_valid, 1'b1);
      @(negedge clk) check1("sel_lat_t2", out_valid, 1'b0);
      @(posedge clk);
      #1;

      // BCAST, ROTATE, REVERSE back-to-back
      issue(2'b01, 4'd15, BASE, EXP_BC15, w0);
      issue(2'b10, 4'd3,  BASE, EXP_ROT3, w1);
      issue(2'b11, 4'd9,  BASE, EXP_REV,  w2);
      in_valid = 1'b0;
      check("b2b_stalls", N'(w0 + w1 + w2), '0);
      @(negedge clk) check1("b2b_valid_2", out_valid, 1'b1);
      @(negedge clk) check1("b2b_valid_3", out_valid, 1'b1);
      @(negedge clk) check1("b2b_valid_end", out_valid, 1'b0);
      @(posedge clk);
      #1;

      // backpressure: two accepted, third stalls, output held
      out_ready = 1'b0;
      issue(2'b00, 4'd0, BASE, EXP_SEL0, w0);
      issue(2'b10, 4'd0, BASE, BASE, w1);
      check("bp_first_two_stalls", N'(w0 + w1), '0);
      in_mode  = 2'b11;
      in_sel   = 4'd0;
      in_data  = BASE;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check1("bp_in_ready", in_ready, 1'b0);
         check("bp_hold", out_data, EXP_SEL0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check1("bp_release_ready", in_ready, 1'b1);
      if (in_ready === 1'b1) sb.push_back(EXP_REV);
      @(posedge clk);
      #1;
      idle(6);

      // flush with both stages full and a third op offered
      out_ready = 1'b0;
      issue(2'b01, 4'd2, BASE, 128'h12121212121212121212121212121212, w0);
      issue(2'b10, 4'd1, BASE, 128'h101F1E1D1C1B1A191817161514131211, w1);
      in_mode  = 2'b11;
      in_data  = BASE;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(negedge clk) check1("flush_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      @(negedge clk) check1("flush_out_valid", out_valid, 1'b0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      idle(5);
      issue(2'b01, 4'd0, BASE, EXP_BC0, w0);
      idle(4);
      check("flush_drained", N'(sb.size()), '0);

      // reset pulse between edges with two ops in flight
      out_ready = 1'b0;
      issue(2'b00, 4'd7, BASE, 128'h17, w0);
      issue(2'b11, 4'd0, BASE, EXP_REV, w1);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check1("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_data", out_data, '0);
      check1("midrst_in_ready", in_ready, 1'b1);
      sb.delete();
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b1;
      idle(4);
      issue(2'b00, 4'd15, BASE, EXP_SELF, w0);
      in_valid = 1'b0;
      @(negedge clk) check1("rst_lat_t0", out_valid, 1'b0);
      @(negedge clk) check1("rst_lat_t1", out_valid, 1'b1);
      @(posedge clk);
      #1;

      // random operations with random backpressure
      rand_ready = 1'b1;
      for (int k = 0; k < 10000; k++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         rm = 2'($urandom_range(0, 3));
         rs = 4'($urandom_range(0, 15));
         rd = {$urandom, $urandom, $urandom, $urandom};
         issue(rm, rs, rd, model(rm, int'(rs), rd), w0);
      end
      in_valid   = 1'b0;
      rand_ready = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      #1 check("rand_drain_empty", N'(sb.size()), '0);
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
